// File: rtl/ads_spi_responder.sv
// ads_spi_responder: SPI mode-0 responder that emulates the ADS converter serial port
// Ports:
//   clk, RESETN           system clock (>= 8x spi_sclk), asynchronous active-low reset
//   spi_cs, spi_sclk      chip select (active-low) and serial clock (idles low) from the master
//   spi_mosi, spi_miso    master-to-responder and responder-to-master data, MSB first
//   alarm_ovw/tflag/aflag alarm flags transmitted in words 0 and 1
//   ch0_data..ch3_data    channel samples transmitted in words 2..5
//   rx_word, rx_valid     last complete master word and its one-clk update strobe
//   word_idx              index of the word the next frame carries
//   pkg_cnt               completed packet count, wraps at 65535
//   frame_err             one-clk strobe on an aborted or overlong frame
module ads_spi_responder #(
  parameter int PKG_WORDS   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RESETN,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [7:0]  alarm_ovw,
  input  logic [7:0]  alarm_tflag,
  input  logic [7:0]  alarm_aflag,
  input  logic [15:0] ch0_data,
  input  logic [15:0] ch1_data,
  input  logic [15:0] ch2_data,
  input  logic [15:0] ch3_data,
  output logic [15:0] rx_word,
  output logic        rx_valid,
  output logic [2:0]  word_idx,
  output logic [15:0] pkg_cnt,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
  logic cs_prev_q, sclk_prev_q;
  logic cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall, start, snap, last_word;
  logic pend_q, pend_d;
  logic [15:0] tx_q, tx_d, rx_shift_q, rx_shift_d, rx_word_q, rx_word_d, pkg_cnt_q, pkg_cnt_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] word_idx_q, word_idx_d;
  logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic [7:0] ovw_q, ovw_d, tflag_q, tflag_d, aflag_q, aflag_d;
  logic [15:0] ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d, sel_word;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  // a cs fall seen during DONE is held in pend_q and taken on the next IDLE cycle
  assign start     = cs_fall | pend_q;

  // The cs synchronizer resets to low: if cs is still low when reset is released
  // (master mid-frame) no fall is seen, so the responder waits for a fresh frame.
  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE  ? (start ? SHIFT : IDLE) :
              state_q == SHIFT ? (cs_rise ? DONE : SHIFT) : IDLE;
  end

  always_comb spi_miso = state_q == SHIFT && bit_cnt_q < 5'd16 && tx_q[15];

  // The packet snapshot is taken as frame 0 starts; word 0 is loaded from the
  // snapshot's next value so it already reflects the freshly captured inputs.
  always_comb begin
    snap      = state_q == IDLE && start && word_idx_q == 3'd0;
    ovw_d     = snap ? alarm_ovw   : ovw_q;
    tflag_d   = snap ? alarm_tflag : tflag_q;
    aflag_d   = snap ? alarm_aflag : aflag_q;
    ch0_d     = snap ? ch0_data    : ch0_q;
    ch1_d     = snap ? ch1_data    : ch1_q;
    ch2_d     = snap ? ch2_data    : ch2_q;
    ch3_d     = snap ? ch3_data    : ch3_q;
    sel_word  = word_idx_q == 3'd0 ? {ovw_d, tflag_d} :
                word_idx_q == 3'd1 ? {aflag_d, pkg_cnt_q[7:0]} :
                word_idx_q == 3'd2 ? ch0_d :
                word_idx_q == 3'd3 ? ch1_d :
                word_idx_q == 3'd4 ? ch2_d : ch3_d;
    last_word = word_idx_q == 3'(PKG_WORDS - 1);
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_word_d  = rx_word_q;
    word_idx_d = word_idx_q;
    pkg_cnt_d  = pkg_cnt_q;
    pend_d     = pend_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        tx_d      = sel_word;
        bit_cnt_d = '0;
        pend_d    = 1'b0;
      end
    end else if (state_q == SHIFT) begin
      if (!cs_rise && sclk_rise) begin
        rx_shift_d = {rx_shift_q[14:0], mosi_s};
        bit_cnt_d  = bit_cnt_q == 5'd17 ? bit_cnt_q : bit_cnt_q + 5'd1;
      end
      if (!cs_rise && sclk_fall && bit_cnt_q < 5'd16) tx_d = {tx_q[14:0], 1'b0};
    end else begin
      pend_d = cs_fall;
      if (bit_cnt_q == 5'd16) begin
        rx_word_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        word_idx_d = last_word ? 3'd0 : word_idx_q + 3'd1;
        pkg_cnt_d  = last_word ? pkg_cnt_q + 16'd1 : pkg_cnt_q;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      tx_q        <= '0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_word_q   <= '0;
      word_idx_q  <= '0;
      pkg_cnt_q   <= '0;
      pend_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovw_q       <= '0;
      tflag_q     <= '0;
      aflag_q     <= '0;
      ch0_q       <= '0;
      ch1_q       <= '0;
      ch2_q       <= '0;
      ch3_q       <= '0;
    end else begin
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_word_q   <= rx_word_d;
      word_idx_q  <= word_idx_d;
      pkg_cnt_q   <= pkg_cnt_d;
      pend_q      <= pend_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      ovw_q       <= ovw_d;
      tflag_q     <= tflag_d;
      aflag_q     <= aflag_d;
      ch0_q       <= ch0_d;
      ch1_q       <= ch1_d;
      ch2_q       <= ch2_d;
      ch3_q       <= ch3_d;
    end
  end

  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign word_idx  = word_idx_q;
  assign pkg_cnt   = pkg_cnt_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ads_spi_responder.sv
// tb_ads_spi_responder: randomized SPI master against a packet-level reference model
module tb_ads_spi_responder;
  localparam int HP  = 5;
  localparam int LAT = 4;
  logic clk = 1'b0, RESETN = 1'b0, spi_cs = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, rx_valid, frame_err;
  logic [7:0] alarm_ovw = '0, alarm_tflag = '0, alarm_aflag = '0;
  logic [15:0] ch0_data = '0, ch1_data = '0, ch2_data = '0, ch3_data = '0;
  logic [15:0] rx_word, pkg_cnt;
  logic [2:0] word_idx;
  int n_tests = 0, n_fail = 0;
  logic [15:0] snap [6];
  logic [15:0] exp_pkt [6] = '{16'h8142, 16'h2400, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
  int m_idx = 0;
  logic [15:0] m_pkg = '0, m_rx = '0;

  always #5 clk = ~clk;

  ads_spi_responder #(.PKG_WORDS(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .RESETN(RESETN), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .alarm_ovw(alarm_ovw), .alarm_tflag(alarm_tflag), .alarm_aflag(alarm_aflag),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
    .rx_word(rx_word), .rx_valid(rx_valid), .word_idx(word_idx), .pkg_cnt(pkg_cnt), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word();
    return m_idx == 1 ? {snap[1][15:8], m_pkg[7:0]} : snap[m_idx];
  endfunction

  task automatic do_frame(input logic [15:0] mo, input int nbits, input bit chg, output logic [15:0] got);
    logic [15:0] exp_w, mask;
    int kv, ke, nv, ne;
    bit full;
    full = nbits == 16;
    if (m_idx == 0) begin
      snap[0] = {alarm_ovw, alarm_tflag};
      snap[1] = {alarm_aflag, 8'h00};
      snap[2] = ch0_data;
      snap[3] = ch1_data;
      snap[4] = ch2_data;
      snap[5] = ch3_data;
    end
    exp_w = model_word();
    got = '0;
    spi_cs = 1'b0;
    repeat (LAT) @(negedge clk);
    check("miso_first_bit", spi_miso, exp_w[15]);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = i < 16 ? mo[15-i] : 1'b0;
      repeat (LAT) @(negedge clk);
      if (i < 16) got[15-i] = spi_miso;
      else check("miso_overlong", spi_miso, 0);
      repeat (HP - LAT) @(negedge clk);
      spi_sclk = 1'b1;
      if (chg && i == 1) ch3_data = 16'hBEEF;
      repeat (HP) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (HP) @(negedge clk);
    mask = nbits >= 16 ? 16'hFFFF : ~(16'hFFFF >> nbits);
    check("miso_word", got & mask, exp_w & mask);
    spi_cs = 1'b1;
    kv = 0; ke = 0; nv = 0; ne = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rx_valid) begin nv++; kv = k; end
      if (frame_err) begin ne++; ke = k; end
    end
    check("rx_valid_pulses", nv, full ? 1 : 0);
    check("rx_valid_delay", kv, full ? 4 : 0);
    check("frame_err_pulses", ne, full ? 0 : 1);
    check("frame_err_delay", ke, full ? 0 : 4);
    if (full) begin
      m_rx = mo;
      if (m_idx == 5) begin m_idx = 0; m_pkg++; end
      else m_idx++;
    end
    check("rx_word", rx_word, m_rx);
    check("word_idx", word_idx, m_idx);
    check("pkg_cnt", pkg_cnt, m_pkg);
    check("miso_idle", spi_miso, 0);
  endtask

  initial begin
    logic [15:0] got, got2;
    int nb;
    repeat (3) @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_rx_word", rx_word, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_word_idx", word_idx, 0);
    check("rst_pkg_cnt", pkg_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    RESETN = 1'b1;
    repeat (4) @(negedge clk);
    ch0_data = 16'h1111; ch1_data = 16'h2222; ch2_data = 16'h3333; ch3_data = 16'h4444;
    alarm_ovw = 8'h81; alarm_tflag = 8'h42; alarm_aflag = 8'h24;
    for (int w = 0; w < 6; w++) begin
      do_frame(16'($urandom), 16, w == 0, got);
      check("packet_word", got, exp_pkt[w]);
    end
    check("packet_count", pkg_cnt, 1);
    for (int w = 0; w < 6; w++) begin
      do_frame(w == 2 ? 16'hC3A5 : 16'($urandom), 16, 1'b0, got);
      if (w == 1) check("word1_low_byte", got[7:0], 8'h01);
      if (w == 2) check("mosi_capture", rx_word, 16'hC3A5);
      if (w == 5) check("snapshot_next_packet", got, 16'hBEEF);
    end
    do_frame(16'h0F0F, 16, 1'b0, got);
    do_frame(16'hFFFF, 9, 1'b0, got);
    check("abort_idx_kept", word_idx, 1);
    do_frame(16'h1234, 16, 1'b0, got2);
    check("abort_resend", got2, 16'h2402);
    do_frame(16'hA5A5, 18, 1'b0, got);
    spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      spi_mosi = 1'($urandom);
      repeat (HP) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HP) @(negedge clk);
      if (i < 6) spi_sclk = 1'b0;
    end
    RESETN = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_miso", spi_miso, 0);
    check("midrst_rx_word", rx_word, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_word_idx", word_idx, 0);
    check("midrst_pkg_cnt", pkg_cnt, 0);
    check("midrst_frame_err", frame_err, 0);
    spi_sclk = 1'b0;
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    RESETN = 1'b1;
    m_idx = 0; m_pkg = '0; m_rx = '0;
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rx_valid || frame_err) nb++;
    end
    check("midrst_no_strobe", nb, 0);
    do_frame(16'h5A5A, 16, 1'b0, got);
    check("midrst_word0", got, {alarm_ovw, alarm_tflag});
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        alarm_ovw = 8'($urandom); alarm_tflag = 8'($urandom); alarm_aflag = 8'($urandom);
        ch0_data = 16'($urandom); ch1_data = 16'($urandom);
        ch2_data = 16'($urandom); ch3_data = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int t = 0; t < 3; t++) begin
          spi_sclk = 1'b1;
          repeat (HP) @(negedge clk);
          spi_sclk = 1'b0;
          repeat (HP) @(negedge clk);
        end
      end
      nb = $urandom_range(0, 4) == 0 ? $urandom_range(1, 18) : 16;
      do_frame(16'($urandom), nb, 1'b0, got);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ads_spi_responder.md
# ads_spi_responder

SPI responder that emulates the ADS converter's serial port so the ADS acquisition chain can be exercised in-system without the external converter. It sits on the far side of the ADS chip-select, clock and data lines driven by the ADS SPI master. It returns a fixed six-word packet of alarm flags and four channel samples. It also captures the 16-bit word the master shifts out in each frame.

## Interface
- PKG_WORDS, 6, words per packet; fixed at 6, index range 0..5
- SYNC_STAGES, 2, synchronizer depth on the spi_cs, spi_sclk and spi_mosi pins (minimum 2)
- clk  in  1  system clock; must be at least 8x the spi_sclk frequency
- RESETN  in  1  reset, asynchronous, active-low
- spi_cs  in  1  chip select from the master, active-low
- spi_sclk  in  1  serial clock from the master; idles low
- spi_mosi  in  1  master-to-responder data
- spi_miso  out  1  responder-to-master data, MSB first
- alarm_ovw  in  8  overview temperature flags
- alarm_tflag  in  8  Ch0..3 temperature flags
- alarm_aflag  in  8  Ch0..3 amplitude flags
- ch0_data, ch1_data, ch2_data, ch3_data  in  16 each  channel samples to transmit
- rx_word  out  16  last completely received master word
- rx_valid  out  1  one-clk pulse when rx_word updates
- word_idx  out  3  index of the word the next frame carries (0..5)
- pkg_cnt  out  16  number of completed packets, wraps at 65535
- frame_err  out  1  one-clk pulse on an aborted or overlong frame

## Operation
- SPI mode 0:
  - The master samples spi_miso on spi_sclk rising; the responder samples spi_mosi on spi_sclk rising.
  - The responder changes spi_miso after spi_sclk falling.
  - A frame is one spi_cs low period of exactly 16 spi_sclk rising edges.
- All three pins pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized signals by comparison with a one-cycle-delayed copy.
- Word content by word_idx:
  - 0: {alarm_ovw, alarm_tflag}
  - 1: {alarm_aflag, pkg_cnt[7:0]}
  - 2: ch0_data
  - 3: ch1_data
  - 4: ch2_data
  - 5: ch3_data
- Snapshot: on the spi_cs falling edge with word_idx = 0, all alarm and channel inputs are registered. Words 0..5 of that packet use the snapshot, so the packet is coherent.
- State machine:
  - IDLE, on cs fall: load the tx shift register with the selected word, bit_cnt = 0, go to SHIFT.
  - SHIFT, on sclk rise: rx_shift = {rx_shift[14:0], mosi}, bit_cnt += 1 (saturates at 17).
  - SHIFT, on sclk fall with bit_cnt < 16: shift tx left by one.
  - SHIFT, on cs rise: go to DONE.
  - DONE, one cycle:
    - If bit_cnt == 16: rx_word = rx_shift, rx_valid pulses, and word_idx advances.
    - word_idx wraps 5 -> 0; on the wrap, pkg_cnt increments.
    - Otherwise (bit_cnt != 16): frame_err pulses, and word_idx, rx_word and pkg_cnt are unchanged. The same word is resent on the next frame.
    - Return to IDLE.
- spi_miso = tx_shift[15] in SHIFT, 0 in IDLE/DONE. No tristate.
- sclk edges while cs is high are ignored.
- A cs fall in DONE is taken on the following IDLE cycle; because of the synchronizer latency, no edge is lost.

## Timing
- Reset values:
  - spi_miso = 0, rx_word = 0, rx_valid = 0, word_idx = 0, pkg_cnt = 0, frame_err = 0.
  - State is IDLE; the snapshot registers are 0.
- RESETN asserted mid-frame drops the frame immediately: no rx_valid, no frame_err. After release, the responder waits for the next cs fall.
- spi_miso shows bit 15 no later than SYNC_STAGES+2 clk after the cs pin falls.
- Each subsequent bit appears within SYNC_STAGES+2 clk after the sclk pin falls.
- rx_valid / frame_err fire SYNC_STAGES+2 clk after the cs pin rises; each is high for exactly 1 clk.
- word_idx and pkg_cnt update on the same clk as rx_valid.

## Test plan
- Packet readback:
  - Stimulus: ch0..3 = 1111, 2222, 3333, 4444; alarm_ovw = 0x81, alarm_tflag = 0x42, alarm_aflag = 0x24; master reads 6 frames.
  - Response: words 0x8142, 0x2400, 0x1111, 0x2222, 0x3333, 0x4444; pkg_cnt = 1.
- Snapshot coherence:
  - Stimulus: change ch3_data to 0xBEEF after frame 0 of the packet starts.
  - Response: word 5 = 0x4444. The next packet returns 0xBEEF, and word 1 low byte = 0x01.
- MOSI capture:
  - Stimulus: master sends 0xC3A5 in one frame.
  - Response: rx_word = 0xC3A5 with a single rx_valid pulse, and word_idx advances by 1.
- Aborted frame:
  - Stimulus: cs rises after 9 sclk.
  - Response: frame_err pulses once, no rx_valid, word_idx unchanged. The next full frame returns the same word.
- Overlong frame:
  - Stimulus: 18 sclk in one frame.
  - Response: frame_err pulses and spi_miso = 0 after bit 16.
- Reset mid-frame and wrap:
  - Stimulus 1: RESETN low during bit 7. Response: all outputs return to reset values and the next frame returns word 0.
  - Stimulus 2: 65536 packets. Response: pkg_cnt wraps to 0.
